// File: rtl/restock_supplier.sv
// Restock supplier: responder end of the store valid/ready restock handshake with a two-item warehouse.
// Optional statistics counters (served_cnt, restock_cnt) are enabled by defining SUPPLIER_STATS_EN.
module restock_supplier #(
    parameter int STOCK_W        = 8,
    parameter int STOCK_INIT     = 100,
    parameter int STOCK_MAX      = 200,
    parameter int PREP_BASE      = 2,
    parameter int RESTOCK_CYCLES = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid,
    input  logic               product,
    input  logic [5:0]         number,
    output logic               ready,
    output logic               busy,
    output logic [STOCK_W-1:0] stock_p1,
    output logic [STOCK_W-1:0] stock_p0
`ifdef SUPPLIER_STATS_EN
    ,
    output logic [15:0]        served_cnt,
    output logic [7:0]         restock_cnt
`endif
);

    localparam int PREP_W = $clog2(PREP_BASE + 8);
    localparam int RS_W   = $clog2(RESTOCK_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, PREP, RESTOCK, GRANT, HOLD} state_t;

    state_t              state;
    logic                req_p;
    logic [5:0]          req_n;
    logic [PREP_W-1:0]   prep_cnt;
    logic [RS_W-1:0]     rs_cnt;
    logic [STOCK_W-1:0]  sel_stock;

    always_comb begin
        sel_stock = req_p ? stock_p1 : stock_p0;
    end

    // NOTE: all state lives in this one block and uses non-blocking assignments so every
    // register updates from the same pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ready    <= 1'b0;
            busy     <= 1'b0;
            stock_p1 <= STOCK_W'(STOCK_INIT);
            stock_p0 <= STOCK_W'(STOCK_INIT);
            req_p    <= 1'b0;
            req_n    <= '0;
            prep_cnt <= '0;
            rs_cnt   <= '0;
`ifdef SUPPLIER_STATS_EN
            served_cnt  <= '0;
            restock_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (valid) begin
                        req_p    <= product;
                        req_n    <= number;
                        // Preparation time grows by one cycle per 8 units requested.
                        prep_cnt <= PREP_W'(PREP_BASE - 1) + PREP_W'(number[5:3]);
                        state    <= PREP;
                        busy     <= 1'b1;
                    end
                end
                PREP: begin
                    if (prep_cnt != '0) begin
                        prep_cnt <= prep_cnt - PREP_W'(1);
                    end else if (!valid) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (sel_stock >= STOCK_W'(req_n)) begin
                        state <= GRANT;
                        ready <= 1'b1;
                    end else begin
                        state  <= RESTOCK;
                        rs_cnt <= RS_W'(RESTOCK_CYCLES - 1);
                    end
                end
                RESTOCK: begin
                    // The restock completes even if the store withdraws; GRANT handles the abort.
                    if (rs_cnt != '0) begin
                        rs_cnt <= rs_cnt - RS_W'(1);
                    end else begin
                        if (req_p) stock_p1 <= STOCK_W'(STOCK_MAX);
                        else       stock_p0 <= STOCK_W'(STOCK_MAX);
                        state <= GRANT;
                        ready <= 1'b1;
`ifdef SUPPLIER_STATS_EN
                        restock_cnt <= restock_cnt + 8'd1;
`endif
                    end
                end
                GRANT: begin
                    ready <= 1'b0;
                    if (valid) begin
                        if (req_p) stock_p1 <= stock_p1 - STOCK_W'(req_n);
                        else       stock_p0 <= stock_p0 - STOCK_W'(req_n);
                        state <= HOLD;
`ifdef SUPPLIER_STATS_EN
                        if (served_cnt != 16'hFFFF) served_cnt <= served_cnt + 16'd1;
`endif
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                HOLD: begin
                    // Swallows the store's valid that lingers one cycle past the handshake.
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
